ahb_slave_mem: RTL and testbench
================================

// Module: ahb_slave_mem
// PURPOSE
//  AHB-Lite slave SRAM sitting directly downstream of the checksum DMA master on the shared bus.
//  It serves the master's data reads at DADR and stores the sum words it writes at CADR.
//  Wait-state insertion is programmable; out-of-range or non-halfword accesses get the AHB two-cycle ERROR.
//  Word-addressed: one address unit = one DATA_WIDTH word, so INCR bursts step HADDR by 1.
// PARAMETERS
//  DATA_WIDTH   16    width of HWDATA/HRDATA and of each memory word
//  ADDR_WIDTH   16    width of HADDR
//  MEM_DEPTH    256   number of words; valid addresses 0..MEM_DEPTH-1
//  WAIT_STATES  0     HREADY-low cycles inserted in every OKAY data phase (0..15)
// PORTS
//  HCLK       in   1           bus clock, all state on rising edge
//  RESET      in   1           asynchronous, active-low reset
//  HSEL       in   1           slave select
//  HADDR      in   ADDR_WIDTH  word address
//  HTRANS     in   2           IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
//  HWRITE     in   1           1=write 0=read
//  HSIZE      in   3           only 3'b001 (halfword) is legal
//  HBURST     in   3           accepted, not used (bursts handled beat by beat)
//  HMASTLOCK  in   1           ignored
//  HWDATA     in   DATA_WIDTH  write data, valid in data phase
//  HRDATA     out  DATA_WIDTH  read data, valid when HREADY=1 in a read data phase
//  HREADY     out  1           1=data phase completes this cycle; also the bus HREADY fed back to the master
//  HRESP      out  1           0=OKAY 1=ERROR
//  DBG_ADDR   in   ADDR_WIDTH  backdoor read address for the bench
//  DBG_RDATA  out  DATA_WIDTH  combinational mem[DBG_ADDR]; 0 if DBG_ADDR >= MEM_DEPTH
// BEHAVIOUR
//  Reset (RESET=0, async):
//   HREADY=1, HRESP=0, HRDATA=0, state=IDLE, wait counter=0, pending phase cleared.
//   Memory contents are not cleared.
//   A reset mid data phase aborts it; a pending write is not performed.
//  Address phase:
//   Sampled on a rising edge with HREADY=1 && HSEL=1 && HTRANS[1]=1.
//   Registers addr_q, write_q, and err = (HADDR>=MEM_DEPTH) || (HSIZE!=3'b001).
//   IDLE/BUSY/HSEL=0 -> no access; next cycle HREADY=1, HRESP=0 (zero-wait OKAY).
//  FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
//   IDLE -> ERR1 on a valid transfer with err=1.
//   IDLE -> WAIT on a valid OKAY transfer when WAIT_STATES>0 (counter loaded with WAIT_STATES).
//   IDLE -> DATA on a valid OKAY transfer when WAIT_STATES=0.
//   WAIT: HREADY=0, HRESP=0; counter decrements each cycle; at count 1 -> DATA.
//   DATA: HREADY=1, HRESP=0.
//    Read: HRDATA=mem[addr_q].
//    Write: mem[addr_q]<=HWDATA on this edge.
//    Pipelined next address phase is sampled on the same edge (same rules as IDLE); none -> IDLE.
//   ERR1: HREADY=0, HRESP=1 -> ERR2.
//   ERR2: HREADY=1, HRESP=1.
//    No memory write.
//    Address phase in this cycle is sampled normally (the master may also cancel with IDLE).
//  Latency:
//   Each OKAY transfer has a data phase of WAIT_STATES+1 cycles.
//   Back-to-back SEQ beats sustain 1 word per WAIT_STATES+1 cycles.
//  Read-after-write to the same address in consecutive beats returns the new data (memory is written at the end of the write's data phase).
//  HRDATA=0 in every cycle that is not a DATA-state read.
//  HWDATA is sampled only in DATA; its value during WAIT is don't-care.
// TESTING
//  Single write 0xA5A5 @0x0010, WAIT_STATES=0 -> one-cycle data phase with HREADY=1; DBG_RDATA@0x0010=0xA5A5.
//  Single read @0x0010 -> HRDATA=0xA5A5 in the cycle after the address phase, HRESP=0.
//  WAIT_STATES=2, INCR burst of 8 writes from 0x0020 (data 1..8), then 8 reads -> each beat has exactly 2 HREADY-low cycles; reads return 1..8.
//  Read @0x0100 (MEM_DEPTH=256) -> ERR1 (HREADY=0,HRESP=1) then ERR2 (HREADY=1,HRESP=1); HSIZE=3'b010 write @0x0005 -> same ERROR, mem[5] unchanged.
//  Write 0x1234 @0x0030 then SEQ read @0x0030 -> read returns 0x1234; IDLE/BUSY with HSEL=1 -> HREADY=1, HRESP=0, no mem change.
//  Assert RESET during WAIT of a write 0xBEEF @0x0040 -> HREADY=1, HRESP=0 immediately; mem[0x40] keeps its old value.

Source files
------------

// File: rtl/ahb_slave_mem.sv
// AHB-Lite word-addressed SRAM slave with programmable wait states and a
// two-cycle ERROR response for out-of-range or non-halfword accesses.
module ahb_slave_mem #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  RESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic                  HMASTLOCK,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADY,
  output logic                  HRESP,
  input  logic [ADDR_WIDTH-1:0] DBG_ADDR,
  output logic [DATA_WIDTH-1:0] DBG_RDATA
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t state, next_state;
  logic [3:0] wait_cnt, next_cnt;
  logic [IDX_W-1:0] addr_q;
  logic write_q;
  logic accept;
  logic req_err;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HMASTLOCK};

  assign req_err = ({1'b0, HADDR} >= DEPTH_L) || (HSIZE != 3'b001);

  // Address phases are only taken in states that drive HREADY high.
  always_comb begin
    next_state = state;
    next_cnt   = wait_cnt;
    HREADY     = 1'b1;
    HRESP      = 1'b0;
    accept     = 1'b0;
    case (state)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        HRESP  = (state == ST_ERR2);
        accept = HSEL && HTRANS[1];
        if (accept) begin
          if (req_err) begin
            next_state = ST_ERR1;
          end else if (WS != 4'd0) begin
            next_state = ST_WAIT;
            next_cnt   = WS;
          end else begin
            next_state = ST_DATA;
          end
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_WAIT: begin
        HREADY   = 1'b0;
        next_cnt = wait_cnt - 4'd1;
        if (wait_cnt == 4'd1) next_state = ST_DATA;
      end
      ST_ERR1: begin
        HREADY     = 1'b0;
        HRESP      = 1'b1;
        next_state = ST_ERR2;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge RESET) begin
    if (!RESET) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      addr_q   <= '0;
      write_q  <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_cnt;
      if (accept) begin
        addr_q  <= HADDR[IDX_W-1:0];
        write_q <= HWRITE;
      end
    end
  end

  // Reset forces the state to IDLE asynchronously, so an interrupted write never lands.
  always_ff @(posedge HCLK) begin
    if (state == ST_DATA && write_q) mem[addr_q] <= HWDATA;
  end

  assign HRDATA    = (state == ST_DATA && !write_q) ? mem[addr_q] : '0;
  assign DBG_RDATA = ({1'b0, DBG_ADDR} < DEPTH_L) ? mem[DBG_ADDR[IDX_W-1:0]] : '0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: two instances (0 and 2 wait states) share one bus,
// selected via HSEL, and are checked against an array-based reference model.
module tb_ahb_slave_mem;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int DEPTH = 256;

  typedef struct {
    logic [15:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [15:0] data;
  } xfer_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic hsel, hwrite, hmastlock;
  logic [AW-1:0] haddr, dbg_addr;
  logic [1:0] htrans;
  logic [2:0] hsize, hburst;
  logic [DW-1:0] hwdata;
  logic [DW-1:0] hrdata_a, hrdata_b, dbg_a, dbg_b;
  logic hready_a, hready_b, hresp_a, hresp_b;
  logic hready, hresp;
  logic [DW-1:0] hrdata;
  int sel;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ref_mem [2][DEPTH];
  bit known [2][DEPTH];
  xfer_t burst_q[$];

  assign hready = (sel == 1) ? hready_b : hready_a;
  assign hresp  = (sel == 1) ? hresp_b  : hresp_a;
  assign hrdata = (sel == 1) ? hrdata_b : hrdata_a;

  ahb_slave_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) u_dut_ws0 (
    .HCLK(clk), .RESET(rst_n), .HSEL(hsel && sel == 0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HMASTLOCK(hmastlock), .HWDATA(hwdata),
    .HRDATA(hrdata_a), .HREADY(hready_a), .HRESP(hresp_a), .DBG_ADDR(dbg_addr), .DBG_RDATA(dbg_a)
  );

  ahb_slave_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .WAIT_STATES(2)) u_dut_ws2 (
    .HCLK(clk), .RESET(rst_n), .HSEL(hsel && sel == 1), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HMASTLOCK(hmastlock), .HWDATA(hwdata),
    .HRDATA(hrdata_b), .HREADY(hready_b), .HRESP(hresp_b), .DBG_ADDR(dbg_addr), .DBG_RDATA(dbg_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ws_of(input int dut);
    return (dut == 1) ? 2 : 0;
  endfunction

  function automatic xfer_t mk(input logic [15:0] a, input logic w, input logic [2:0] s,
                               input logic [15:0] d);
    xfer_t t;
    t.addr = a; t.write = w; t.size = s; t.data = d;
    return t;
  endfunction

  task automatic drive_addr(input xfer_t t, input bit first);
    hsel   = 1'b1;
    haddr  = t.addr;
    hwrite = t.write;
    hsize  = t.size;
    htrans = first ? 2'b10 : 2'b11;
    hburst = 3'b001;
  endtask

  task automatic drive_idle();
    hsel   = 1'b1;
    htrans = 2'b00;
    hburst = 3'b000;
  endtask

  // Runs every transfer in burst_q back to back, pipelining each next address phase.
  task automatic applyStimulus(input int dut);
    int n;
    xfer_t t;
    bit err;
    int low;
    bit resp_bad;
    int exp_low;
    string tag;
    sel = dut;
    n = burst_q.size();
    for (int i = 0; i < n; i++) begin
      t = burst_q[i];
      if (i == 0) drive_addr(t, 1'b1);
      @(posedge clk);
      #1;
      hwdata = t.write ? t.data : 16'($urandom);
      if (i + 1 < n) drive_addr(burst_q[i+1], 1'b0);
      else drive_idle();
      err = (t.addr >= DEPTH) || (t.size != 3'b001);
      exp_low = err ? 1 : ws_of(dut);
      tag = $sformatf("d%0d_%s_%0h", dut, t.write ? "wr" : "rd", t.addr);
      low = 0;
      resp_bad = 1'b0;
      @(negedge clk);
      while (hready !== 1'b1 && low < 40) begin
        if (hresp !== err) resp_bad = 1'b1;
        low++;
        @(negedge clk);
      end
      checkOutput({tag, "_lowcycles"}, low, exp_low);
      if (exp_low > 0) checkOutput({tag, "_waitresp"}, {31'd0, resp_bad}, 0);
      checkOutput({tag, "_resp"}, {31'd0, hresp}, {31'd0, err});
      if (!err && !t.write) begin
        if (known[dut][t.addr[7:0]]) checkOutput({tag, "_rdata"}, hrdata, ref_mem[dut][t.addr[7:0]]);
      end else begin
        checkOutput({tag, "_rdata0"}, hrdata, 0);
      end
      if (!err && t.write) begin
        ref_mem[dut][t.addr[7:0]] = t.data;
        known[dut][t.addr[7:0]] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    burst_q.delete();
  endtask

  task automatic check_mem(input int dut, input logic [15:0] a, input logic [15:0] exp);
    dbg_addr = a;
    #1;
    checkOutput($sformatf("d%0d_dbg_%0h", dut, a), (dut == 1) ? dbg_b : dbg_a, exp);
  endtask

  initial begin
    xfer_t t;
    int blen;
    sel = 0; rst_n = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'b001; hburst = 3'b000; hmastlock = 1'b0; hwdata = '0; dbg_addr = '0;
    #12;
    checkOutput("reset_hready_a", {31'd0, hready_a}, 1);
    checkOutput("reset_hready_b", {31'd0, hready_b}, 1);
    checkOutput("reset_hresp_a", {31'd0, hresp_a}, 0);
    checkOutput("reset_hresp_b", {31'd0, hresp_b}, 0);
    checkOutput("reset_hrdata_a", hrdata_a, 0);
    checkOutput("reset_hrdata_b", hrdata_b, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single write and read-back with zero wait states
    burst_q.push_back(mk(16'h0010, 1'b1, 3'b001, 16'hA5A5));
    applyStimulus(0);
    check_mem(0, 16'h0010, 16'hA5A5);
    burst_q.push_back(mk(16'h0010, 1'b0, 3'b001, 16'h0000));
    applyStimulus(0);

    // Eight-beat INCR bursts with two wait states per beat
    for (int i = 0; i < 8; i++) burst_q.push_back(mk(16'(32 + i), 1'b1, 3'b001, 16'(i + 1)));
    applyStimulus(1);
    for (int i = 0; i < 8; i++) burst_q.push_back(mk(16'(32 + i), 1'b0, 3'b001, 16'h0000));
    applyStimulus(1);
    for (int i = 0; i < 8; i++) check_mem(1, 16'(32 + i), 16'(i + 1));

    // Out-of-range read and wrong-size write both get ERROR
    burst_q.push_back(mk(16'h0005, 1'b1, 3'b001, 16'h5555));
    applyStimulus(0);
    burst_q.push_back(mk(16'h0100, 1'b0, 3'b001, 16'h0000));
    burst_q.push_back(mk(16'h0005, 1'b1, 3'b010, 16'hDEAD));
    applyStimulus(0);
    check_mem(0, 16'h0005, 16'h5555);
    check_mem(0, 16'h0100, 16'h0000);

    // Read-after-write in consecutive beats
    burst_q.push_back(mk(16'h0030, 1'b1, 3'b001, 16'h1234));
    burst_q.push_back(mk(16'h0030, 1'b0, 3'b001, 16'h0000));
    applyStimulus(0);

    // BUSY then IDLE while selected: zero-wait OKAY, no memory change
    sel = 0;
    hsel = 1'b1; haddr = 16'h0030; hwrite = 1'b1; hsize = 3'b001; htrans = 2'b01; hwdata = 16'hFFFF;
    @(posedge clk);
    #1 htrans = 2'b00;
    @(negedge clk);
    checkOutput("busy_hready", {31'd0, hready}, 1);
    checkOutput("busy_hresp", {31'd0, hresp}, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("idle_hready", {31'd0, hready}, 1);
    checkOutput("idle_hresp", {31'd0, hresp}, 0);
    @(posedge clk);
    #1;
    check_mem(0, 16'h0030, 16'h1234);

    // Reset asserted during the wait phase of a write aborts it
    burst_q.push_back(mk(16'h0040, 1'b1, 3'b001, 16'h7777));
    applyStimulus(1);
    sel = 1;
    drive_addr(mk(16'h0040, 1'b1, 3'b001, 16'hBEEF), 1'b1);
    @(posedge clk);
    #1 hwdata = 16'hBEEF;
    drive_idle();
    @(negedge clk);
    checkOutput("rst_in_wait_hready", {31'd0, hready}, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_hready", {31'd0, hready}, 1);
    checkOutput("rst_hresp", {31'd0, hresp}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_mem(1, 16'h0040, 16'h7777);

    // Random bursts on either slave
    for (int b = 0; b < 150; b++) begin
      blen = $urandom_range(1, 4);
      for (int k = 0; k < blen; k++) begin
        t.addr  = ($urandom_range(0, 9) == 0) ? 16'(256 + $urandom_range(0, 300))
                                              : 16'($urandom_range(0, 63));
        t.write = 1'($urandom_range(0, 1));
        t.size  = ($urandom_range(0, 11) == 0) ? 3'b010 : 3'b001;
        t.data  = 16'($urandom);
        burst_q.push_back(t);
      end
      applyStimulus(int'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    for (int d = 0; d < 2; d++)
      for (int a = 0; a < DEPTH; a++)
        if (known[d][a]) check_mem(d, 16'(a), ref_mem[d][a]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
